dsm_rx_demod: RTL and testbench

DSM_RX_DEMOD -- requirements
Module: dsm_rx_demod

---
 rtl/dsm_rx_pkg.sv | 53 +++++
 rtl/dsm_rx_cic.sv | 74 +++++++
 rtl/dsm_rx_demod.sv | 89 ++++++++
 tb/tb_dsm_rx_demod.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dsm_rx_pkg.sv
// -----------------------------------------------------------------------------
// dsm_rx_pkg -- shared constants, types and helpers for the delta-sigma
// receive demodulator (dsm_rx_demod / dsm_rx_cic).
//
// Contents:
//   CIC_N / CIC_R / CIC_W  CIC order, decimation ratio, datapath width
//   OUT_W                  width of the recovered output sample
//   sym_code_e             2-bit line code of one delta-sigma symbol
//   LO_WEIGHT              local-oscillator weight indexed by LO phase
//   sym_decode()           line code -> signed symbol value (illegal -> 0)
//   sat_out()              saturate a CIC-width value to OUT_W bits
// -----------------------------------------------------------------------------
package dsm_rx_pkg;

  localparam int CIC_N = 3;
  localparam int CIC_R = 32;
  localparam int CIC_W = 18;
  localparam int OUT_W = 15;
  localparam int CNT_W = $clog2(CIC_R);

  // Same encoding as the transmit-side LO/mixer.
  typedef enum logic [1:0] {
    SYM_ZERO = 2'b00,
    SYM_POS  = 2'b01,
    SYM_NEG  = 2'b10,
    SYM_ILL  = 2'b11
  } sym_code_e;

  typedef logic signed [1:0]       sym_t;
  typedef logic signed [CIC_W-1:0] acc_t;
  typedef logic signed [OUT_W-1:0] out_t;

  // Weight applied at LO phase 0..3: +1, 0, -1, 0.
  localparam sym_t LO_WEIGHT [4] = '{2'sd1, 2'sd0, -2'sd1, 2'sd0};

  localparam acc_t SAT_HI = CIC_W'((1 << (OUT_W - 1)) - 1);
  localparam acc_t SAT_LO = CIC_W'(-(1 << (OUT_W - 1)));

  function automatic sym_t sym_decode(input logic [1:0] code);
    case (code)
      SYM_POS: return 2'sd1;
      SYM_NEG: return -2'sd1;
      default: return 2'sd0;  // zero and the illegal code both count as 0
    endcase
  endfunction

  function automatic out_t sat_out(input acc_t v);
    if (v > SAT_HI)      return SAT_HI[OUT_W-1:0];
    else if (v < SAT_LO) return SAT_LO[OUT_W-1:0];
    else                 return v[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/dsm_rx_cic.sv
// -----------------------------------------------------------------------------
// dsm_rx_cic -- 3-stage CIC decimator, R=32, M=1, 18-bit wrap arithmetic.
//
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous active-high reset
//   en       in   accepts x this cycle (en=0 freezes integrators and counter)
//   x        in   signed 2-bit input sample (-1, 0, +1)
//   y        out  signed CIC_W-bit decimated result, held between updates
//   y_valid  out  one-cycle pulse, one cycle after the comb load
//
// Timing: the 32nd accepted sample updates the integrators on its edge and
// arms a load; the next edge runs the comb chain and registers y/y_valid.
// The load/output pipeline keeps moving when en drops so a completed frame
// always emerges with fixed latency.
// -----------------------------------------------------------------------------
module dsm_rx_cic
  import dsm_rx_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  sym_t       x,
  output acc_t       y,
  output logic       y_valid
);

  acc_t             integ     [CIC_N];
  acc_t             integ_nxt [CIC_N];
  acc_t             dly       [CIC_N];
  acc_t             comb      [CIC_N];
  logic [CNT_W-1:0] dec_cnt;
  logic             load;

  // Integrators are cascaded within one sample so the chain adds no latency;
  // combs are evaluated only in the load cycle and their delays captured then.
  always_comb begin
    // NOTE: every element is assigned on every pass, so no latch can be inferred.
    integ_nxt[0] = integ[0] + acc_t'(x);
    for (int i = 1; i < CIC_N; i++) integ_nxt[i] = integ[i] + integ_nxt[i-1];
    comb[0] = integ[CIC_N-1] - dly[0];
    for (int i = 1; i < CIC_N; i++) comb[i] = comb[i-1] - dly[i];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the integrator/comb arrays are a handful of flops, not RAM, and
      // must be cleared so a partial frame cannot leak into the next output.
      for (int i = 0; i < CIC_N; i++) begin
        integ[i] <= '0;
        dly[i]   <= '0;
      end
      dec_cnt <= '0;
      load    <= 1'b0;
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking updates let the comb load read the integrator value
      // from the previous edge even when a new sample arrives this cycle.
      y_valid <= load;
      load    <= en && (dec_cnt == CNT_W'(CIC_R - 1));
      if (en) begin
        for (int i = 0; i < CIC_N; i++) integ[i] <= integ_nxt[i];
        dec_cnt <= dec_cnt + 1'b1;  // wraps 31 -> 0
      end
      if (load) begin
        dly[0] <= integ[CIC_N-1];
        for (int i = 1; i < CIC_N; i++) dly[i] <= comb[i-1];
        y <= comb[CIC_N-1];
      end
    end
  end

endmodule

// File: rtl/dsm_rx_demod.sv
// -----------------------------------------------------------------------------
// dsm_rx_demod -- delta-sigma symbol receiver: decode, optional LO mixing,
// CIC decimation, scaling and saturation to a 15-bit sample.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous active-high reset (wins over en/lo_sync)
//   en          in   symbol-accept strobe
//   lo_sync     in   one-cycle LO phase realign pulse
//   pwm_in      in   symbol code: 01=+1, 00=0, 10=-1, 11=illegal (used as 0)
//   dout        out  signed recovered sample, held between pulses
//   dout_valid  out  one-cycle pulse, two cycles after the 32nd symbol
//   code_err    out  one-cycle pulse the cycle after an accepted 11 symbol
//
// Build option DSM_RX_MIX_EN: when defined, each symbol is multiplied by the
// LO weight of its phase and dout = sat(cic). When undefined, symbols feed the
// CIC directly, lo_sync is ignored and dout = sat(cic >>> 1).
// -----------------------------------------------------------------------------
module dsm_rx_demod
  import dsm_rx_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic       lo_sync,
  input  logic [1:0] pwm_in,
  output out_t       dout,
  output logic       dout_valid,
  output logic       code_err
);

  sym_t sym;
  sym_t cic_x;
  acc_t cic_y;
  logic cic_y_valid;
  acc_t scaled;

  assign sym = sym_decode(pwm_in);

`ifdef DSM_RX_MIX_EN
  logic [1:0]        lo_phase;
  logic [1:0]        eff_phase;
  logic signed [3:0] prod;

  // lo_sync forces phase 0 for a symbol accepted in the same cycle.
  always_comb begin
    eff_phase = lo_sync ? 2'd0 : lo_phase;
    prod      = sym * LO_WEIGHT[eff_phase];
    cic_x     = prod[1:0];  // product is always -1, 0 or +1
  end

  always_ff @(posedge clock) begin
    if (reset)        lo_phase <= 2'd0;
    else if (en)      lo_phase <= eff_phase + 2'd1;
    else if (lo_sync) lo_phase <= 2'd0;
  end

  assign scaled = cic_y;
`else
  logic unused_lo_sync;

  assign unused_lo_sync = lo_sync;
  assign cic_x          = sym;
  // DC gain of the CIC is 2^15; halving keeps full scale near the 15-bit limit.
  assign scaled         = cic_y >>> 1;
`endif

  dsm_rx_cic u_cic (
    .clock   (clock),
    .reset   (reset),
    .en      (en),
    .x       (cic_x),
    .y       (cic_y),
    .y_valid (cic_y_valid)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      code_err   <= 1'b0;
    end else begin
      dout_valid <= cic_y_valid;
      code_err   <= en && (pwm_in == SYM_ILL);
      if (cic_y_valid) dout <= sat_out(scaled);
    end
  end

endmodule

// File: tb/tb_dsm_rx_demod.sv
// -----------------------------------------------------------------------------
// tb_dsm_rx_demod -- directed self-checking bench for dsm_rx_demod.
// Expected values follow from the CIC DC gain (32^3 = 32768) and the scaling
// rule of the selected build (DSM_RX_MIX_EN defined or not).
// -----------------------------------------------------------------------------
module tb_dsm_rx_demod;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              en = 1'b0;
  logic              lo_sync = 1'b0;
  logic [1:0]        pwm_in = 2'b00;
  logic signed [14:0] dout;
  logic              dout_valid;
  logic              code_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int vq[$];
  int tq[$];
  int err_cnt = 0;
  int consec = 0;
  logic prev_valid = 1'b0;
  int c0;

`ifdef DSM_RX_MIX_EN
  localparam int EXP_CONST = 0;       // +1 times zero-mean LO weights
  localparam int EXP_PAT   = 16383;
  localparam int EXP_PAT2  = -16384;
`else
  localparam int EXP_CONST = 16383;   // 32768 >>> 1 saturates
  localparam int EXP_PAT   = 0;
  localparam int EXP_PAT2  = 0;
`endif

  dsm_rx_demod dut (
    .clock      (clock),
    .reset      (reset),
    .en         (en),
    .lo_sync    (lo_sync),
    .pwm_in     (pwm_in),
    .dout       (dout),
    .dout_valid (dout_valid),
    .code_err   (code_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (dout_valid) begin
      vq.push_back(int'(dout));
      tq.push_back(cyc);
      if (prev_valid) consec++;
    end
    if (code_err) err_cnt++;
    prev_valid = dout_valid;
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply(input logic e, input logic [1:0] code, input logic sync);
    en = e;
    pwm_in = code;
    lo_sync = sync;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 2'b00, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en = 1'b0;
    lo_sync = 1'b0;
    pwm_in = 2'b00;
    tick();
    tick();
    reset = 1'b0;
    vq.delete();
    tq.delete();
    err_cnt = 0;
    c0 = cyc;
  endtask

  function automatic int qv(input int i);
    return (i < vq.size()) ? vq[i] : -999999;
  endfunction

  function automatic int qt(input int i);
    return (i < tq.size()) ? tq[i] : -999999;
  endfunction

  initial begin
    // Reset state
    do_reset();
    check("rst_dout", int'(dout), 0);
    check("rst_valid", int'(dout_valid), 0);
    check("rst_code_err", int'(code_err), 0);

    // A: constant +1, en=1
    do_reset();
    for (int k = 1; k <= 128; k++) apply(1'b1, 2'b01, 1'b0);
    idle(4);
    check("A_count", vq.size(), 4);
    check("A_first_time", qt(0), c0 + 34);
    check("A_period", qt(1) - qt(0), 32);
    check("A_period3", qt(3) - qt(2), 32);
    check("A_dout3", qv(2), EXP_CONST);
    check("A_dout4", qv(3), EXP_CONST);
    idle(5);
    check("A_hold", int'(dout), EXP_CONST);

    // B: alternating +1/-1
    do_reset();
    for (int k = 1; k <= 128; k++) apply(1'b1, (k % 2) ? 2'b01 : 2'b10, 1'b0);
    idle(4);
    check("B_count", vq.size(), 4);
    check("B_dout3", qv(2), 0);
    check("B_dout4", qv(3), 0);

    // C: constant 0
    do_reset();
    for (int k = 1; k <= 96; k++) apply(1'b1, 2'b00, 1'b0);
    idle(4);
    check("C_count", vq.size(), 3);
    check("C_dout1", qv(0), 0);
    check("C_dout2", qv(1), 0);
    check("C_dout3", qv(2), 0);

    // D: lo_sync then 01,00,10,00 repeating, and the 2-phase shifted pattern
    do_reset();
    apply(1'b0, 2'b00, 1'b1);
    for (int k = 0; k < 128; k++)
      apply(1'b1, (k % 4 == 0) ? 2'b01 : (k % 4 == 2) ? 2'b10 : 2'b00, 1'b0);
    idle(4);
    check("D_count", vq.size(), 4);
    check("D_dout3", qv(2), EXP_PAT);
    check("D_dout4", qv(3), EXP_PAT);
    do_reset();
    apply(1'b0, 2'b00, 1'b1);
    for (int k = 0; k < 128; k++)
      apply(1'b1, (k % 4 == 0) ? 2'b10 : (k % 4 == 2) ? 2'b01 : 2'b00, 1'b0);
    idle(4);
    check("D2_dout3", qv(2), EXP_PAT2);
    check("D2_dout4", qv(3), EXP_PAT2);

    // E: en toggling 1,0 with constant +1
    do_reset();
    for (int k = 1; k <= 256; k++) apply((k % 2) == 1, 2'b01, 1'b0);
    idle(4);
    check("E_count", vq.size(), 4);
    check("E_first_time", qt(0), c0 + 65);
    check("E_period", qt(1) - qt(0), 64);
    check("E_period2", qt(2) - qt(1), 64);
    check("E_dout3", qv(2), EXP_CONST);

    // F: illegal code at symbol 5 in an all-zero stream
    do_reset();
    for (int k = 1; k <= 96; k++) begin
      apply(1'b1, (k == 5) ? 2'b11 : 2'b00, 1'b0);
      if (k == 5) check("F_err_pulse", int'(code_err), 1);
      if (k == 6) check("F_err_clear", int'(code_err), 0);
    end
    idle(4);
    check("F_err_count", err_cnt, 1);
    check("F_count", vq.size(), 3);
    check("F_dout1", qv(0), 0);
    check("F_dout2", qv(1), 0);
    check("F_dout3", qv(2), 0);

    // G: reset at symbol 20 of a frame (with en and an illegal code present)
    do_reset();
    for (int k = 1; k <= 83; k++) apply(1'b1, 2'b01, 1'b0);
    check("G_pre_nonzero", int'(dout != 0), 1);
    reset = 1'b1;
    en = 1'b1;
    pwm_in = 2'b11;
    lo_sync = 1'b1;
    tick();
    check("G_dout_clr", int'(dout), 0);
    check("G_valid_clr", int'(dout_valid), 0);
    check("G_err_clr", int'(code_err), 0);
    reset = 1'b0;
    vq.delete();
    tq.delete();
    c0 = cyc;
    for (int k = 1; k <= 40; k++) apply(1'b1, 2'b01, 1'b0);
    check("G_count", vq.size(), 1);
    check("G_first_time", qt(0), c0 + 34);

    // I: lo_sync mid-frame does not disturb decimation timing
    do_reset();
    for (int k = 1; k <= 64; k++) apply(1'b1, 2'b00, k == 10);
    idle(4);
    check("I_first_time", qt(0), c0 + 34);
    check("I_period", qt(1) - qt(0), 32);

    check("no_consecutive_valid", consec, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
